adv7179_init_seq: RTL and testbench
===================================

# adv7179_init_seq

Bring-up sequencer for the ADV7179 video encoder. After reset it drives the encoder's hardware reset pin through a timed low/settle window. It then walks an external register table and issues one I2C register write per entry to the byte-level I2C write engine over a req/ack handshake, retrying NACKed writes. It sits between the system clock domain and the I2C master inside the ADV7179 configuration path and raises `finish7179` when the encoder is configured.

## Interface
- `RST_LOW_CYC`, 5900: cycles `ADV7179_RST` is held low (100 µs at 59 MHz).
- `RST_WAIT_CYC`, 59000: cycles after `ADV7179_RST` release before the first write.
- `NUM_REGS`, 16: table entries, 1..32.
- `MAX_RETRY`, 3: retries per entry after a NACK, giving 1+MAX_RETRY attempts total.
- `GAP_CYC`, 16: idle cycles after every completed or NACKed transaction, at least 1.
- `DEV_ADDR`, 8'h54: ADV7179 I2C write address.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; reruns the full sequence from DONE or ERROR.
- `ADV7179_RST`  out  1  encoder hardware reset, active low.
- `rom_addr`  out  5  table index.
- `rom_data`  in  16  table entry: [15:8] register address, [7:0] value; valid 1 cycle after `rom_addr`.
- `wr_req`  out  1  write request to the I2C engine.
- `wr_dev`  out  8  device address; constant `DEV_ADDR`.
- `wr_addr`  out  8  register address.
- `wr_data`  out  8  register value.
- `wr_ack`  in  1  one-cycle pulse: write completed, slave ACKed.
- `wr_nack`  in  1  one-cycle pulse: write aborted, slave NACKed.
- `finish7179`  out  1  level; configuration complete.
- `cfg_err`  out  1  level; retries exhausted.

## Operation
- Reset (`rst`=0 at a clk edge) forces these outputs: `ADV7179_RST`=0, `wr_req`=0, `wr_addr`=0, `wr_data`=0, `rom_addr`=0, `finish7179`=0, `cfg_err`=0. It also zeroes the index and retry counters. State goes to RST_LO. A mid-sequence reset aborts at once; `wr_req` drops on the same edge.
- RST_LO: `ADV7179_RST`=0 for RST_LOW_CYC cycles, then go to RST_WAIT.
- RST_WAIT: `ADV7179_RST`=1 for RST_WAIT_CYC cycles, then go to FETCH.
- FETCH: drive `rom_addr`=idx for one cycle, then go to LOAD.
- LOAD: latch `wr_addr`=rom_data[15:8] and `wr_data`=rom_data[7:0], clear the retry count, then go to REQ.
- REQ: hold `wr_req`=1 until `wr_ack` or `wr_nack` is sampled high.
  - `wr_addr` and `wr_data` stay stable while `wr_req`=1.
  - If both pulses arrive in the same cycle, `wr_nack` wins.
- GAP: hold for GAP_CYC cycles, then:
  - after an ACK: if idx=NUM_REGS-1, go to DONE; otherwise idx+1, go to FETCH.
  - after a NACK with retry<MAX_RETRY: retry+1, go to REQ with the latched addr/data. No ROM refetch.
  - after a NACK with retry=MAX_RETRY: go to ERROR.
- DONE: `finish7179`=1 and held.
- ERROR: `cfg_err`=1 and held; `ADV7179_RST` stays 1.
- `start` in DONE or ERROR:
  - clears `finish7179`, `cfg_err`, idx and retry;
  - goes to RST_LO on the next edge.
- `start` in any other state is ignored.
- `wr_ack`/`wr_nack` outside REQ are ignored.
- `finish7179` and `cfg_err` are never 1 together.
- Counters are sized with `$clog2` of their parameter (minimum 1 bit) and compare against param-1. They never wrap.
- idx is 5 bits. NUM_REGS=32 ends at idx=31 with no overflow.

## Timing
- Cycle 0 is the first edge with `rst`=1.
- `ADV7179_RST` is 0 through cycle RST_LOW_CYC-1 and 1 from cycle RST_LOW_CYC.
- FETCH is at cycle RST_LOW_CYC+RST_WAIT_CYC.
- LOAD is one cycle later.
- `wr_req` first rises at cycle RST_LOW_CYC+RST_WAIT_CYC+2.
- `wr_req` falls on the edge after the ack/nack sample. It is 0 for at least GAP_CYC cycles between requests.
- Per-entry overhead beyond I2C time: GAP_CYC+2 cycles (GAP, FETCH, LOAD).
- A retry re-raises `wr_req` exactly GAP_CYC cycles after it falls.
- `finish7179` rises the cycle after the last GAP ends.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
All scenarios use RST_LOW_CYC=4, RST_WAIT_CYC=8, NUM_REGS=3, GAP_CYC=2, MAX_RETRY=2.

- Reset release with a ROM of {0x0011, 0x0122, 0x0233} and an engine that ACKs 5 cycles after `wr_req`:
  - `ADV7179_RST` is low on cycles 0-3.
  - The first `wr_req` is at cycle 14 with addr 0x00 / data 0x11.
  - Three writes occur in order.
  - `finish7179`=1 after the last GAP; `cfg_err`=0.
- Entry 1 NACKed twice, then ACKed:
  - three requests for 0x01/0x22, each after a 2-cycle gap;
  - no ROM refetch (`rom_addr` stays 1);
  - ends with `finish7179`=1.
- Entry 0 NACKed three times:
  - `cfg_err`=1 after the third NACK's GAP;
  - no further `wr_req`; `finish7179`=0.
- `wr_ack` and `wr_nack` in the same cycle: treated as a NACK (retry count increments). A stray `wr_ack` during RST_WAIT has no effect.
- `rst` low while `wr_req`=1 mid-table: on that edge `wr_req`=0, `ADV7179_RST`=0 and `rom_addr`=0. After release the sequence restarts with entry 0.
- `start` pulse in DONE: `finish7179` clears the next cycle, `ADV7179_RST` goes low for 4 cycles, and the full table is rewritten. A `start` pulse during REQ is ignored.

Source files
------------

// File: rtl/adv7179_init_seq.sv
// ADV7179 bring-up sequencer: drives the encoder reset pulse, then walks the register
// table and issues one I2C write per entry, retrying NACKed writes up to MAX_RETRY times.
module adv7179_init_seq #(
   parameter int         RST_LOW_CYC  = 5900,
   parameter int         RST_WAIT_CYC = 59000,
   parameter int         NUM_REGS     = 16,
   parameter int         MAX_RETRY    = 3,
   parameter int         GAP_CYC      = 16,
   parameter logic [7:0] DEV_ADDR     = 8'h54
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        ADV7179_RST,
   output logic [4:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic        wr_req,
   output logic [7:0]  wr_dev,
   output logic [7:0]  wr_addr,
   output logic [7:0]  wr_data,
   input  logic        wr_ack,
   input  logic        wr_nack,
   output logic        finish7179,
   output logic        cfg_err
);

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // One shared timer covers the reset-low, reset-wait and gap windows.
   localparam int TMR_W = cnt_width(max3(RST_LOW_CYC, RST_WAIT_CYC, GAP_CYC));
   localparam int RTY_W = cnt_width(MAX_RETRY + 1);

   localparam logic [TMR_W-1:0] LOW_LAST  = TMR_W'(RST_LOW_CYC - 1);
   localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(RST_WAIT_CYC - 1);
   localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYC - 1);
   localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(MAX_RETRY);
   localparam logic [4:0]       IDX_LAST  = 5'(NUM_REGS - 1);

   localparam logic [2:0] S_RST_LO   = 3'd0;
   localparam logic [2:0] S_RST_WAIT = 3'd1;
   localparam logic [2:0] S_FETCH    = 3'd2;
   localparam logic [2:0] S_LOAD     = 3'd3;
   localparam logic [2:0] S_REQ      = 3'd4;
   localparam logic [2:0] S_GAP      = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;
   localparam logic [2:0] S_ERROR    = 3'd7;

   logic [2:0]       state_reg;
   logic [TMR_W-1:0] tmr_reg;
   logic [RTY_W-1:0] retry_reg;
   logic [4:0]       idx_reg;
   logic [4:0]       rom_addr_reg;
   logic             enc_rst_reg;
   logic             wr_req_reg;
   logic [7:0]       wr_addr_reg;
   logic [7:0]       wr_data_reg;
   logic             last_nack_reg;
   logic             finish_reg;
   logic             cfg_err_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= S_RST_LO;
         tmr_reg       <= '0;
         retry_reg     <= '0;
         idx_reg       <= '0;
         rom_addr_reg  <= '0;
         enc_rst_reg   <= 1'b0;
         wr_req_reg    <= 1'b0;
         wr_addr_reg   <= '0;
         wr_data_reg   <= '0;
         last_nack_reg <= 1'b0;
         finish_reg    <= 1'b0;
         cfg_err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            S_RST_LO: begin
               if (tmr_reg == LOW_LAST) begin
                  tmr_reg     <= '0;
                  enc_rst_reg <= 1'b1;
                  state_reg   <= S_RST_WAIT;
               end else begin
                  tmr_reg <= tmr_reg + TMR_W'(1);
               end
            end
            S_RST_WAIT: begin
               if (tmr_reg == WAIT_LAST) begin
                  tmr_reg      <= '0;
                  rom_addr_reg <= idx_reg;
                  state_reg    <= S_FETCH;
               end else begin
                  tmr_reg <= tmr_reg + TMR_W'(1);
               end
            end
            S_FETCH: begin
               state_reg <= S_LOAD;
            end
            S_LOAD: begin
               wr_addr_reg <= rom_data[15:8];
               wr_data_reg <= rom_data[7:0];
               retry_reg   <= '0;
               wr_req_reg  <= 1'b1;
               state_reg   <= S_REQ;
            end
            S_REQ: begin
               // NACK takes priority when both responses land together.
               if (wr_nack) begin
                  wr_req_reg    <= 1'b0;
                  last_nack_reg <= 1'b1;
                  tmr_reg       <= '0;
                  state_reg     <= S_GAP;
               end else if (wr_ack) begin
                  wr_req_reg    <= 1'b0;
                  last_nack_reg <= 1'b0;
                  tmr_reg       <= '0;
                  state_reg     <= S_GAP;
               end
            end
            S_GAP: begin
               if (tmr_reg == GAP_LAST) begin
                  tmr_reg <= '0;
                  if (!last_nack_reg) begin
                     if (idx_reg == IDX_LAST) begin
                        finish_reg <= 1'b1;
                        state_reg  <= S_DONE;
                     end else begin
                        idx_reg      <= idx_reg + 5'd1;
                        rom_addr_reg <= idx_reg + 5'd1;
                        state_reg    <= S_FETCH;
                     end
                  end else if (retry_reg == RTY_LAST) begin
                     cfg_err_reg <= 1'b1;
                     state_reg   <= S_ERROR;
                  end else begin
                     // Retry reuses the latched addr/data; the table is not re-read.
                     retry_reg  <= retry_reg + RTY_W'(1);
                     wr_req_reg <= 1'b1;
                     state_reg  <= S_REQ;
                  end
               end else begin
                  tmr_reg <= tmr_reg + TMR_W'(1);
               end
            end
            S_DONE, S_ERROR: begin
               if (start) begin
                  finish_reg    <= 1'b0;
                  cfg_err_reg   <= 1'b0;
                  idx_reg       <= '0;
                  retry_reg     <= '0;
                  rom_addr_reg  <= '0;
                  tmr_reg       <= '0;
                  enc_rst_reg   <= 1'b0;
                  last_nack_reg <= 1'b0;
                  state_reg     <= S_RST_LO;
               end
            end
            default: begin
               state_reg <= S_RST_LO;
            end
         endcase
      end
   end

   assign ADV7179_RST = enc_rst_reg;
   assign rom_addr    = rom_addr_reg;
   assign wr_req      = wr_req_reg;
   assign wr_dev      = DEV_ADDR;
   assign wr_addr     = wr_addr_reg;
   assign wr_data     = wr_data_reg;
   assign finish7179  = finish_reg;
   assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_adv7179_init_seq.sv
// Randomized bench for adv7179_init_seq: a table-walking reference model predicts every
// request cycle, address, data and the final outcome from a per-attempt response plan.
module tb_adv7179_init_seq;

   localparam int RL = 4;
   localparam int RW = 8;
   localparam int NR = 3;
   localparam int GP = 2;
   localparam int MR = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        adv_rst;
   logic [4:0]  rom_addr;
   logic [15:0] rom_data = '0;
   logic        wr_req;
   logic [7:0]  wr_dev;
   logic [7:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        wr_ack = 1'b0;
   logic        wr_nack = 1'b0;
   logic        finish7179;
   logic        cfg_err;

   adv7179_init_seq #(
      .RST_LOW_CYC (RL),
      .RST_WAIT_CYC(RW),
      .NUM_REGS    (NR),
      .MAX_RETRY   (MR),
      .GAP_CYC     (GP),
      .DEV_ADDR    (8'h54)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ADV7179_RST(adv_rst),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .wr_req     (wr_req),
      .wr_dev     (wr_dev),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ack     (wr_ack),
      .wr_nack    (wr_nack),
      .finish7179 (finish7179),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   logic [15:0] rom [0:31];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int vectors = 0;
   int fails = 0;
   int cyc = 0;
   int plan_lat[$];
   int plan_kind[$];   // 0 = ACK, 1 = NACK, 2 = ACK and NACK together
   int exp_t[$];
   int exp_e[$];
   int m_end;
   bit m_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      wr_ack  = 1'b0;
      wr_nack = 1'b0;
      start   = 1'b0;
   endtask

   task automatic new_plan(input int mode);
      int r;
      plan_lat.delete();
      plan_kind.delete();
      for (int i = 0; i < 12; i++) begin
         plan_lat.push_back(int'($urandom_range(1, 6)));
         r = int'($urandom_range(0, 9));
         if (mode == 0) plan_kind.push_back(0);
         else plan_kind.push_back(r < 6 ? 0 : (r < 8 ? 1 : 2));
      end
   endtask

   task automatic new_rom();
      for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
   endtask

   // Each entry gets attempts until an ACK or the retry budget is spent.
   task automatic build_model();
      int t, p, att, fall;
      bit adv_e;
      exp_t.delete();
      exp_e.delete();
      t = RL + RW + 2;
      p = 0;
      m_done = 1'b0;
      m_end = 0;
      for (int e = 0; e < NR; e++) begin
         att = 0;
         adv_e = 1'b0;
         while (!adv_e) begin
            exp_t.push_back(t);
            exp_e.push_back(e);
            fall = t + plan_lat[p];
            if (plan_kind[p] == 0) begin
               adv_e = 1'b1;
               if (e == NR - 1) begin
                  m_end = fall + GP;
                  m_done = 1'b1;
               end else begin
                  t = fall + GP + 2;
               end
            end else begin
               att++;
               if (att > MR) begin
                  m_end = fall + GP;
                  return;
               end
               t = fall + GP;
            end
            p++;
         end
      end
   endtask

   task automatic run_scn(input int abort_at, input int stray_cyc, input bit start_in_req);
      int k, hold, cur, n, e;
      bit prev;
      k = 0; hold = 0; cur = -1; prev = 1'b0;
      build_model();
      n = exp_t.size();
      while (cyc <= m_end + 10) begin
         if (cyc <= RL) chk("adv_rst_window", adv_rst, (cyc >= RL) ? 1 : 0);
         if (wr_req && !prev) begin
            $display("req %0d cyc=%0d rom_addr=%0d addr=%02h data=%02h", k, cyc, rom_addr, wr_addr, wr_data);
            if (k < n) begin
               e = exp_e[k];
               chk("req_cycle", cyc, exp_t[k]);
               chk("req_addr", wr_addr, {24'd0, rom[e][15:8]});
               chk("req_data", wr_data, {24'd0, rom[e][7:0]});
               chk("req_rom_addr", rom_addr, e);
               chk("req_dev", wr_dev, 8'h54);
               cur = k;
            end else begin
               chk("extra_req", k, n);
            end
            k++;
            hold = 0;
            if (abort_at != 0 && k == abort_at) return;
         end
         if (cyc == m_end - 1) chk("flags_before_end", {finish7179, cfg_err}, 0);
         if (cyc == m_end || cyc == m_end + 10) begin
            chk("finish_end", finish7179, m_done ? 1 : 0);
            chk("cfg_err_end", cfg_err, m_done ? 0 : 1);
            chk("adv_rst_end", adv_rst, 1);
            chk("wr_req_end", wr_req, 0);
         end
         prev = wr_req;
         if (wr_req) begin
            hold++;
            if (cur >= 0 && hold == plan_lat[cur]) begin
               wr_ack  = (plan_kind[cur] != 1);
               wr_nack = (plan_kind[cur] != 0);
            end
            if (start_in_req && cur == 0 && hold == 1) start = 1'b1;
         end else begin
            hold = 0;
         end
         if (cyc == stray_cyc) wr_ack = 1'b1;
         tick();
      end
      chk("req_count", k, n);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      cyc = 0;
   endtask

   initial begin
      rom[0] = 16'h0011; rom[1] = 16'h0122; rom[2] = 16'h0233;
      for (int i = 3; i < 32; i++) rom[i] = 16'h0;
      @(negedge clk);
      tick(); tick(); tick();
      chk("rst_adv", adv_rst, 0);
      chk("rst_wr_req", wr_req, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_finish", finish7179, 0);
      chk("rst_cfg_err", cfg_err, 0);

      // Fixed table, ACK after 5 cycles, stray ACK during the reset wait
      plan_lat.delete(); plan_kind.delete();
      for (int i = 0; i < 12; i++) begin plan_lat.push_back(5); plan_kind.push_back(0); end
      rst = 1'b1;
      cyc = 0;
      run_scn(0, 6, 1'b0);

      // Entry 1 NACKed twice then ACKed; start during REQ is ignored
      new_rom();
      new_plan(0);
      plan_kind[1] = 1; plan_kind[2] = 1;
      do_start();
      chk("start_clears_finish", finish7179, 0);
      run_scn(0, -1, 1'b1);

      // Entry 0 NACKed on every attempt
      new_rom();
      new_plan(0);
      plan_kind[0] = 1; plan_kind[1] = 1; plan_kind[2] = 1;
      do_start();
      run_scn(0, -1, 1'b0);

      // From ERROR: simultaneous ACK+NACK counts as a NACK
      new_rom();
      new_plan(0);
      plan_kind[0] = 2;
      do_start();
      chk("start_clears_err", cfg_err, 0);
      run_scn(0, -1, 1'b0);

      // Reset while the second request is pending
      new_rom();
      new_plan(0);
      do_start();
      run_scn(2, -1, 1'b0);
      rst = 1'b0;
      tick();
      chk("midrst_wr_req", wr_req, 0);
      chk("midrst_adv", adv_rst, 0);
      chk("midrst_rom_addr", rom_addr, 0);
      tick();
      new_plan(1);
      rst = 1'b1;
      cyc = 0;
      run_scn(0, -1, 1'b0);

      for (int s = 0; s < 6; s++) begin
         new_rom();
         new_plan(1);
         do_start();
         run_scn(0, -1, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
